sec_timer: RTL

SEC_TIMER -- requirements
Module: sec_timer

---
 rtl/sec_timer.sv | 113 +++++++++++
 1 files changed

// File: rtl/sec_timer.sv
// Seconds timer: a CLK_DIV-cycle prescaler drives a SEC_W-bit seconds count
// with optional expiry at a programmable limit (one-shot or auto-reload).
module sec_timer #(
    parameter int unsigned CLK_DIV = 50000000,
    parameter int unsigned PULSE_W = 27,
    parameter int unsigned SEC_W   = 4
) (
    input  logic             clk,
    input  logic             reseta,
    input  logic             clear,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [SEC_W-1:0] limit,
    output logic [SEC_W-1:0] timeout,
    output logic             tick,
    output logic             expired,
    output logic             running,
    output logic             DoneResetClock
);

    localparam logic [PULSE_W-1:0] PULSE_MAX = PULSE_W'(CLK_DIV - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [PULSE_W-1:0] pulse_q;
    logic [PULSE_W-1:0] pulse_d;
    logic [SEC_W-1:0]   timeout_d;
    logic               tick_d;
    logic               expired_d;
    logic               done_d;
    logic [SEC_W-1:0]   secs_inc_c;
    logic               wrap_c;
    logic               hit_c;

    // Wrap is suppressed by clear or stop in the same cycle; expiry uses live limit.
    assign secs_inc_c = SEC_W'(timeout + SEC_W'(1));
    assign wrap_c     = (state_q == ST_RUN) && !clear && !stop && (pulse_q == PULSE_MAX);
    assign hit_c      = (limit != '0) && (secs_inc_c == limit);

    // State register: running/idle.
    always_ff @(posedge clk or negedge reseta) begin
        if (!reseta) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: clear > stop > one-shot expiry > start.
    always_comb begin
        state_d = state_q;
        if (clear || stop) begin
            state_d = ST_IDLE;
        end else if (wrap_c && hit_c && !mode) begin
            state_d = ST_IDLE;
        end else if ((state_q == ST_IDLE) && start) begin
            state_d = ST_RUN;
        end
    end

    // Output next values: prescaler, seconds count and one-cycle pulses.
    always_comb begin
        pulse_d   = pulse_q;
        timeout_d = timeout;
        tick_d    = 1'b0;
        expired_d = 1'b0;
        done_d    = 1'b0;
        if (clear) begin
            pulse_d   = '0;
            timeout_d = '0;
            done_d    = 1'b1;
        end else if (!stop && (state_q == ST_RUN)) begin
            if (wrap_c) begin
                pulse_d = '0;
                tick_d  = 1'b1;
                if (hit_c) begin
                    expired_d = 1'b1;
                    timeout_d = mode ? '0 : limit;
                end else begin
                    timeout_d = secs_inc_c;
                end
            end else begin
                pulse_d = PULSE_W'(pulse_q + PULSE_W'(1));
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge reseta) begin
        if (!reseta) begin
            pulse_q        <= '0;
            timeout        <= '0;
            tick           <= 1'b0;
            expired        <= 1'b0;
            DoneResetClock <= 1'b0;
        end else begin
            pulse_q        <= pulse_d;
            timeout        <= timeout_d;
            tick           <= tick_d;
            expired        <= expired_d;
            DoneResetClock <= done_d;
        end
    end

    assign running = (state_q == ST_RUN);

endmodule
